// File: rtl/decode_pkg.sv
// Shared decode-path constants: format codes, immediate shift codes,
// micro-op field layout and functional-unit codes.
package decode_pkg;

   typedef enum logic [4:0] {
      FMT_INVALID = 5'd0,
      FMT_A       = 5'd1,
      FMT_B       = 5'd2,
      FMT_C       = 5'd3,
      FMT_D       = 5'd4,
      FMT_E       = 5'd5,
      FMT_F       = 5'd6
   } fmt_e;

   // DS and DQ forms scale the displacement; HI16 places it in the upper half-word
   typedef enum logic [1:0] {
      SH_NONE = 2'd0,
      SH_DS   = 2'd1,
      SH_DQ   = 2'd2,
      SH_HI16 = 2'd3
   } shift_e;

   localparam int UOP_RA_OFS    = 0;
   localparam int UOP_RA_W      = 5;
   localparam int UOP_RB_OFS    = 5;
   localparam int UOP_RB_W      = 5;
   localparam int UOP_RT_OFS    = 10;
   localparam int UOP_RT_W      = 5;
   localparam int UOP_USES_OFS  = 15;
   localparam int UOP_USES_W    = 8;
   localparam int UOP_EN_OFS    = 23;
   localparam int UOP_EN_W      = 16;
   localparam int UOP_XOPC_OFS  = 39;
   localparam int UOP_XOPC_W    = 21;
   localparam int UOP_FU_OFS    = 60;
   localparam int UOP_FU_W      = 4;

   typedef enum logic [3:0] {
      FU_NONE   = 4'd0,
      FU_ALU    = 4'd1,
      FU_LDST   = 4'd2,
      FU_BRANCH = 4'd3,
      FU_MUL    = 4'd4,
      FU_DIV    = 4'd5,
      FU_SPR    = 4'd6
   } fu_e;

endpackage

// File: rtl/decode_mux_queue_if.sv
// Bundle between the format decoders, the decode queue and the issue stage.
interface decode_mux_queue_if #(
   parameter int NUM_CH    = 6,
   parameter int UOP_W     = 64,
   parameter int IMM_IN_W  = 16,
   parameter int IMM_OUT_W = 64,
   parameter int ADDR_W    = 64,
   parameter int OPC_W     = 6,
   parameter int FMT_W     = 5,
   parameter int ERR_CNT_W = 8
);
   logic [ADDR_W-1:0]          instructionAddress_i;
   logic [OPC_W-1:0]           opcode_i;
   logic [NUM_CH-1:0]          chanValid_i;
   logic [NUM_CH*UOP_W-1:0]    chanUop_i;
   logic [NUM_CH*IMM_IN_W-1:0] chanImm_i;
   logic [NUM_CH-1:0]          chanImmSigned_i;
   logic [NUM_CH*2-1:0]        chanImmShift_i;
   logic                       ready_o;
   logic                       valid_o;
   logic                       ready_i;
   logic [UOP_W-1:0]           uop_o;
   logic [IMM_OUT_W-1:0]       imm_o;
   logic [FMT_W-1:0]           format_o;
   logic [ADDR_W-1:0]          instructionAddress_o;
   logic [OPC_W-1:0]           opcode_o;
   logic                       multiHot_o;
   logic [ERR_CNT_W-1:0]       multiHotCount_o;

   modport slave (
      input  instructionAddress_i, opcode_i, chanValid_i, chanUop_i, chanImm_i,
             chanImmSigned_i, chanImmShift_i, ready_i,
      output ready_o, valid_o, uop_o, imm_o, format_o, instructionAddress_o,
             opcode_o, multiHot_o, multiHotCount_o
   );

   modport master (
      output instructionAddress_i, opcode_i, chanValid_i, chanUop_i, chanImm_i,
             chanImmSigned_i, chanImmShift_i, ready_i,
      input  ready_o, valid_o, uop_o, imm_o, format_o, instructionAddress_o,
             opcode_o, multiHot_o, multiHotCount_o
   );
endinterface

// File: rtl/decode_skid_fifo.sv
// Generic circular-buffer queue with ready/valid; head data comes straight
// from the storage registers, so there is no input-to-output bypass.
module decode_skid_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign ready_o = (r_count != CNT_W'(DEPTH));
   assign valid_o = (r_count != '0);
   assign w_push  = push_i & ready_o;
   assign w_pop   = pop_i & valid_o;
   assign data_o  = r_mem[r_head];

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= data_i;
            r_tail        <= r_tail + PTR_W'(1);
         end
         if (w_pop) r_head <= r_head + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end
endmodule

// File: rtl/decode_mux_queue.sv
// Second decode stage: picks the active format-decoder channel, normalises its
// immediate and queues the result toward issue with ready/valid back-pressure.
module decode_mux_queue
   import decode_pkg::*;
#(
   parameter int NUM_CH    = 6,
   parameter int UOP_W     = 64,
   parameter int IMM_IN_W  = 16,
   parameter int IMM_OUT_W = 64,
   parameter int ADDR_W    = 64,
   parameter int OPC_W     = 6,
   parameter int FMT_W     = 5,
   parameter int DEPTH     = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               flush_i,
   decode_mux_queue_if.slave  bus
);
   localparam int ENT_W = UOP_W + IMM_OUT_W + FMT_W + ADDR_W + OPC_W;

   logic [UOP_W-1:0]     w_uop;
   logic [IMM_IN_W-1:0]  w_immRaw;
   logic                 w_immSigned;
   logic [1:0]           w_immShift;
   logic [IMM_OUT_W-1:0] w_imm;
   logic [FMT_W-1:0]     w_fmt;
   logic                 w_any;
   logic                 w_multi;
   logic                 w_ready;
   logic                 w_valid;
   logic                 w_push;
   logic [ENT_W-1:0]     w_head;
   logic                 r_multiHot;
   logic [ERR_CNT_W-1:0] r_multiHotCount;

   function automatic logic [IMM_OUT_W-1:0] normalise_imm(
      input logic [IMM_IN_W-1:0] raw,
      input logic                sgn,
      input shift_e              sh
   );
      logic [IMM_OUT_W-1:0] ext;
      ext = sgn ? {{(IMM_OUT_W-IMM_IN_W){raw[IMM_IN_W-1]}}, raw}
                : {{(IMM_OUT_W-IMM_IN_W){1'b0}}, raw};
      case (sh)
         SH_NONE: normalise_imm = ext;
         SH_DS:   normalise_imm = ext << 2;
         SH_DQ:   normalise_imm = ext << 4;
         SH_HI16: normalise_imm = ext << 16;
      endcase
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + ERR_CNT_W'(1);
   endfunction

   // Channel k sits at the MSB end of every bus; walking from the highest
   // channel down lets the lowest valid index win the priority.
   always_comb begin
      w_uop       = '0;
      w_immRaw    = '0;
      w_immSigned = 1'b0;
      w_immShift  = 2'd0;
      w_fmt       = FMT_W'(FMT_INVALID);
      w_any       = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (bus.chanValid_i[NUM_CH-1-k]) begin
            w_uop       = bus.chanUop_i[(NUM_CH-1-k)*UOP_W +: UOP_W];
            w_immRaw    = bus.chanImm_i[(NUM_CH-1-k)*IMM_IN_W +: IMM_IN_W];
            w_immSigned = bus.chanImmSigned_i[NUM_CH-1-k];
            w_immShift  = bus.chanImmShift_i[(NUM_CH-1-k)*2 +: 2];
            w_fmt       = FMT_W'(k + 1);
            w_any       = 1'b1;
         end
      end
   end

   assign w_multi = ($countones(bus.chanValid_i) > 1);
   assign w_imm   = normalise_imm(w_immRaw, w_immSigned, shift_e'(w_immShift));
   assign w_push  = w_any & w_ready & ~flush_i;

   decode_skid_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .push_i  (w_push),
      .data_i  ({w_uop, w_imm, w_fmt, bus.instructionAddress_i, bus.opcode_i}),
      .pop_i   (bus.ready_i),
      .ready_o (w_ready),
      .valid_o (w_valid),
      .data_o  (w_head)
   );

   // Error reporting only counts inputs that were actually accepted.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_multiHot      <= 1'b0;
         r_multiHotCount <= '0;
      end else begin
         r_multiHot <= w_push & w_multi;
         if (w_push & w_multi) r_multiHotCount <= sat_inc(r_multiHotCount);
      end
   end

   assign bus.ready_o         = w_ready;
   assign bus.valid_o         = w_valid;
   assign {bus.uop_o, bus.imm_o, bus.format_o, bus.instructionAddress_o, bus.opcode_o} = w_head;
   assign bus.multiHot_o      = r_multiHot;
   assign bus.multiHotCount_o = r_multiHotCount;
endmodule

// File: tb/tb_decode_mux_queue.sv
// Scoreboard bench for decode_mux_queue: stimulus pushes hand-computed
// expectations, a negedge monitor pops them whenever the head is consumed.
module tb_decode_mux_queue;
   logic clk = 1'b0;
   logic rst;
   logic flush;

   always #5 clk = ~clk;

   decode_mux_queue_if bus ();

   decode_mux_queue dut (
      .clock_i (clk),
      .reset_i (rst),
      .flush_i (flush),
      .bus     (bus.slave)
   );

   typedef struct packed {
      logic [63:0] uop;
      logic [63:0] imm;
      logic [4:0]  fmt;
      logic [63:0] addr;
      logic [5:0]  opc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_cnt;
   logic        m_mh;
   logic [7:0]  m_mhc;
   bit          mon_on = 1'b0;
   logic [63:0] ch_uop [6];

   localparam logic [63:0] IMM_CH0 = 64'h0000_0000_8001_0000;
   localparam logic [63:0] IMM_CH1 = 64'h0000_0000_0000_0004;
   localparam logic [63:0] IMM_CH2 = 64'h0000_0000_0000_7FFF;
   localparam logic [63:0] IMM_CH3 = 64'hFFFF_FFFF_FFFF_8000;
   localparam logic [63:0] IMM_CH4 = 64'h0000_0000_0000_0FF0;
   localparam logic [63:0] IMM_CH5 = 64'hFFFF_FFFF_8000_0000;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load_chan(input int k, input logic [63:0] uop, input logic [15:0] imm,
                            input logic sgn, input logic [1:0] sh);
      bus.chanUop_i[(5-k)*64 +: 64]    = uop;
      bus.chanImm_i[(5-k)*16 +: 16]    = imm;
      bus.chanImmSigned_i[5-k]         = sgn;
      bus.chanImmShift_i[(5-k)*2 +: 2] = sh;
      ch_uop[k]                        = uop;
   endtask

   // One clock: check handshake/error outputs against the occupancy model,
   // record any accepted input, then advance to just after the rising edge.
   task automatic step(input exp_t e, input bit multi);
      bit acc;
      @(negedge clk);
      check("ready_o", 64'(bus.ready_o), 64'(m_cnt != 2));
      check("valid_o", 64'(bus.valid_o), 64'(m_cnt != 0));
      check("multiHot_o", 64'(bus.multiHot_o), 64'(m_mh));
      check("multiHotCount_o", 64'(bus.multiHotCount_o), 64'(m_mhc));
      acc = (bus.chanValid_i != '0) && (m_cnt != 2) && !flush && !rst;
      if (rst) begin
         m_cnt = 0; exp_q.delete(); m_mh = 1'b0; m_mhc = 8'd0;
      end else if (flush) begin
         m_cnt = 0; exp_q.delete(); m_mh = 1'b0;
      end else begin
         if (acc) exp_q.push_back(e);
         m_cnt = m_cnt + (acc ? 1 : 0) - ((m_cnt != 0 && bus.ready_i) ? 1 : 0);
         m_mh  = acc && multi;
         if (acc && multi && m_mhc != 8'hFF) m_mhc = m_mhc + 8'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exp_t z;
      z = '0;
      bus.chanValid_i = '0;
      step(z, 1'b0);
   endtask

   task automatic issue(input logic [5:0] vld, input int ch, input logic [63:0] e_imm,
                        input logic [63:0] addr, input logic [5:0] opc);
      exp_t e;
      bus.chanValid_i          = vld;
      bus.instructionAddress_i = addr;
      bus.opcode_i             = opc;
      e.uop  = ch_uop[ch];
      e.imm  = e_imm;
      e.fmt  = 5'(ch + 1);
      e.addr = addr;
      e.opc  = opc;
      step(e, $countones(vld) > 1);
      bus.chanValid_i = '0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_on && bus.valid_o === 1'b1 && bus.ready_i === 1'b1 && !flush && !rst) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_head: got valid_o=1 format %0d, required no entry", bus.format_o);
            end else begin
               mon_e = exp_q.pop_front();
               check("head_uop",  bus.uop_o, mon_e.uop);
               check("head_imm",  bus.imm_o, mon_e.imm);
               check("head_fmt",  64'(bus.format_o), 64'(mon_e.fmt));
               check("head_addr", bus.instructionAddress_o, mon_e.addr);
               check("head_opc",  64'(bus.opcode_o), 64'(mon_e.opc));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      bus.instructionAddress_i = '0;
      bus.opcode_i = '0;
      bus.chanValid_i = '0;
      bus.chanUop_i = '0;
      bus.chanImm_i = '0;
      bus.chanImmSigned_i = '0;
      bus.chanImmShift_i = '0;
      bus.ready_i = 1'b0;
      m_cnt = 0; m_mh = 1'b0; m_mhc = 8'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_valid", 64'(bus.valid_o), 64'd0);
      check("reset_ready", 64'(bus.ready_o), 64'd1);
      check("reset_mhcount", 64'(bus.multiHotCount_o), 64'd0);
      check("reset_imm", bus.imm_o, 64'd0);
      check("reset_fmt", 64'(bus.format_o), 64'd0);
      @(posedge clk);
      #1 mon_on = 1'b1;

      load_chan(0, 64'hC0C0_0000_0000_00C0, 16'h8001, 1'b0, 2'd3);
      load_chan(1, 64'h1111_0000_0000_0011, 16'h0001, 1'b1, 2'd1);
      load_chan(2, 64'h2222_0000_0000_0022, 16'h7FFF, 1'b1, 2'd0);
      load_chan(3, 64'h3333_0000_0000_0033, 16'hF800, 1'b1, 2'd2);
      load_chan(4, 64'h4444_0000_0000_0044, 16'h00FF, 1'b0, 2'd2);
      load_chan(5, 64'h5555_0000_0000_0055, 16'h8000, 1'b1, 2'd3);

      // single channels through an idle queue
      bus.ready_i = 1'b1;
      issue(6'b000100, 3, IMM_CH3, 64'h0000_0000_0000_1000, 6'h12);
      check("ch3_valid", 64'(bus.valid_o), 64'd1);
      check("ch3_fmt", 64'(bus.format_o), 64'd4);
      check("ch3_imm", bus.imm_o, 64'hFFFF_FFFF_FFFF_8000);
      idle();
      issue(6'b100000, 0, IMM_CH0, 64'h0000_0000_0000_2000, 6'h21);
      check("ch0_fmt", 64'(bus.format_o), 64'd1);
      check("ch0_imm", bus.imm_o, 64'h0000_0000_8001_0000);
      idle();

      // back-pressure with the consumer stalled
      bus.ready_i = 1'b0;
      issue(6'b010000, 1, IMM_CH1, 64'h0000_0000_0000_3000, 6'h01);
      issue(6'b001000, 2, IMM_CH2, 64'h0000_0000_0000_3004, 6'h02);
      check("bp_full_ready", 64'(bus.ready_o), 64'd0);
      issue(6'b000001, 5, IMM_CH5, 64'h0000_0000_0000_3008, 6'h03);
      check("bp_still_valid", 64'(bus.valid_o), 64'd1);
      bus.ready_i = 1'b1;
      idle();
      idle();
      check("bp_ready_back", 64'(bus.ready_o), 64'd1);
      check("bp_empty", 64'(bus.valid_o), 64'd0);
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // multi-hot: channels 0 and 3 valid, channel 0 must win
      issue(6'b100100, 0, IMM_CH0, 64'h0000_0000_0000_4000, 6'h30);
      check("mh_pulse", 64'(bus.multiHot_o), 64'd1);
      check("mh_count1", 64'(bus.multiHotCount_o), 64'd1);
      check("mh_fmt", 64'(bus.format_o), 64'd1);
      idle();
      check("mh_pulse_end", 64'(bus.multiHot_o), 64'd0);
      for (int i = 1; i < 300; i++)
         issue(6'b100100, 0, IMM_CH0, 64'h0000_0000_0000_4000 + 64'(i), 6'h30);
      idle();
      check("mh_saturate", 64'(bus.multiHotCount_o), 64'd255);

      // flush while full with a concurrent valid input
      bus.ready_i = 1'b0;
      issue(6'b000010, 4, IMM_CH4, 64'h0000_0000_0000_5000, 6'h04);
      issue(6'b000001, 5, IMM_CH5, 64'h0000_0000_0000_5004, 6'h05);
      flush = 1'b1;
      bus.ready_i = 1'b1;
      issue(6'b100100, 0, IMM_CH0, 64'h0000_0000_0000_5008, 6'h06);
      flush = 1'b0;
      check("flush_valid", 64'(bus.valid_o), 64'd0);
      check("flush_ready", 64'(bus.ready_o), 64'd1);
      check("flush_no_mh", 64'(bus.multiHot_o), 64'd0);
      check("flush_keep_count", 64'(bus.multiHotCount_o), 64'd255);
      issue(6'b001000, 2, IMM_CH2, 64'h0000_0000_0000_500C, 6'h07);
      idle();
      idle();
      check("flush_after_single", 64'(exp_q.size()), 64'd0);

      // simultaneous push and pop at count 1
      bus.ready_i = 1'b0;
      issue(6'b010000, 1, IMM_CH1, 64'h0000_0000_0000_6000, 6'h08);
      bus.ready_i = 1'b1;
      issue(6'b001000, 2, IMM_CH2, 64'h0000_0000_0000_6004, 6'h09);
      check("pp_valid", 64'(bus.valid_o), 64'd1);
      check("pp_new_head", 64'(bus.format_o), 64'd3);
      idle();
      check("pp_drained", 64'(exp_q.size()), 64'd0);

      // reset asserted mid-stream drops everything
      bus.ready_i = 1'b0;
      issue(6'b000100, 3, IMM_CH3, 64'h0000_0000_0000_7000, 6'h0A);
      issue(6'b000010, 4, IMM_CH4, 64'h0000_0000_0000_7004, 6'h0B);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      check("rst_mid_valid", 64'(bus.valid_o), 64'd0);
      check("rst_mid_ready", 64'(bus.ready_o), 64'd1);
      check("rst_mid_imm", bus.imm_o, 64'd0);
      check("rst_mid_uop", bus.uop_o, 64'd0);
      check("rst_mid_count", 64'(bus.multiHotCount_o), 64'd0);
      bus.ready_i = 1'b1;
      idle();
      idle();
      check("final_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
